// File: rtl/dmem_access_unit_if.sv
// ---------------------------------------------------------------------------
// dmem_access_unit_if
//   Bundles the pipeline-side request/response signals and the word-wide
//   data-memory bus used by dmem_access_unit.
//
//   Pipeline side : req_read, req_write, acc_mode, addr, wdata  -> unit
//                   rdata, stall, misalign, bus_err             <- unit
//   Memory side   : mem_req, mem_we, mem_addr, mem_be, mem_wdata <- unit
//                   mem_rdata, mem_ack                           -> unit
//
//   Modports:
//     slave  - the access unit itself
//     master - whoever drives the pipeline request and models the memory
// ---------------------------------------------------------------------------
interface dmem_access_unit_if;
  logic        req_read;
  logic        req_write;
  logic [2:0]  acc_mode;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        misalign;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  req_read, req_write, acc_mode, addr, wdata, mem_rdata, mem_ack,
    output rdata, stall, misalign, bus_err,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_read, req_write, acc_mode, addr, wdata, mem_rdata, mem_ack,
    input  rdata, stall, misalign, bus_err,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/dmem_access_unit.sv
// ---------------------------------------------------------------------------
// dmem_access_unit
//   MEM-stage data-memory responder. Takes the EX/MEM load/store request,
//   runs one req/ack transaction on the word-wide memory bus, formats load
//   data (byte/halfword select, sign/zero extension) and holds the pipeline
//   with a combinational stall until the access is finished.
//
//   Ports:
//     clk    - system clock
//     reset  - synchronous, active-high reset
//     bus    - dmem_access_unit_if.slave (request, result, status, memory bus)
//
//   Parameter:
//     TIMEOUT_CYCLES - REQ cycles without mem_ack before the access is aborted
//
//   Build option:
//     DMEM_TIMEOUT_EN - when defined, a REQ that sees no ack for
//                       TIMEOUT_CYCLES cycles is aborted and bus_err pulses;
//                       when undefined, REQ waits indefinitely and bus_err
//                       is tied low.
// ---------------------------------------------------------------------------
module dmem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  dmem_access_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic        memReq_q, memReq_d;
  logic        memWe_q, memWe_d;
  logic [29:0] memAddr_q, memAddr_d;
  logic [3:0]  memBe_q, memBe_d;
  logic [31:0] memWdata_q, memWdata_d;
  logic [2:0]  accMode_q, accMode_d;
  logic [1:0]  offset_q, offset_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misalign_q, misalign_d;
  logic        busErr_q, busErr_d;
  logic        stall;
  logic        reqValid;
  logic        reqLegal;

`ifdef DMEM_TIMEOUT_EN
  logic [31:0] waitCnt_q, waitCnt_d;
`endif

  // Word needs a 4-byte aligned address, half a 2-byte aligned one, bytes
  // are always aligned; modes 5-7 are never legal.
  function automatic logic isLegal(input logic [2:0] mode, input logic [1:0] off);
    case (mode)
      3'd0:       isLegal = (off == 2'b00);
      3'd1, 3'd2: isLegal = ~off[0];
      3'd3, 3'd4: isLegal = 1'b1;
      default:    isLegal = 1'b0;
    endcase
  endfunction

  // Little-endian lane enables: bit0 is the byte at offset 0.
  function automatic logic [3:0] byteEnables(input logic [2:0] mode, input logic [1:0] off);
    case (mode)
      3'd0:       byteEnables = 4'b1111;
      3'd1, 3'd2: byteEnables = off[1] ? 4'b1100 : 4'b0011;
      default:    byteEnables = 4'b0001 << off;
    endcase
  endfunction

  // Narrow stores are replicated into every lane so the enabled lane always
  // carries the right bytes regardless of offset.
  function automatic logic [31:0] storeLanes(input logic [2:0] mode, input logic [31:0] data);
    case (mode)
      3'd0:       storeLanes = data;
      3'd1, 3'd2: storeLanes = {2{data[15:0]}};
      default:    storeLanes = {4{data[7:0]}};
    endcase
  endfunction

  function automatic logic [31:0] formatLoad(input logic [2:0] mode, input logic [1:0] off,
                                             input logic [31:0] raw);
    logic [15:0] half;
    logic [7:0]  byteSel;
    half = off[1] ? raw[31:16] : raw[15:0];
    case (off)
      2'd0:    byteSel = raw[7:0];
      2'd1:    byteSel = raw[15:8];
      2'd2:    byteSel = raw[23:16];
      default: byteSel = raw[31:24];
    endcase
    case (mode)
      3'd1:    formatLoad = {{16{half[15]}}, half};
      3'd2:    formatLoad = {16'h0000, half};
      3'd3:    formatLoad = {{24{byteSel[7]}}, byteSel};
      3'd4:    formatLoad = {24'h000000, byteSel};
      default: formatLoad = raw;
    endcase
  endfunction

  assign reqValid = bus.req_read | bus.req_write;
  assign reqLegal = isLegal(bus.acc_mode, bus.addr[1:0]);

  // Next-state and output logic. Every registered value holds by default;
  // stall is raised when a legal request is accepted and throughout REQ,
  // released in DONE so the pipeline advances on that edge, and forced low
  // during reset.
  always_comb begin
    state_d    = state_q;
    memReq_d   = memReq_q;
    memWe_d    = memWe_q;
    memAddr_d  = memAddr_q;
    memBe_d    = memBe_q;
    memWdata_d = memWdata_q;
    accMode_d  = accMode_q;
    offset_d   = offset_q;
    rdata_d    = rdata_q;
    misalign_d = 1'b0;
    busErr_d   = 1'b0;
    stall      = 1'b0;
`ifdef DMEM_TIMEOUT_EN
    waitCnt_d  = waitCnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (reqValid) begin
          if (reqLegal) begin
            stall      = 1'b1;
            memReq_d   = 1'b1;
            memWe_d    = bus.req_write;
            memAddr_d  = bus.addr[31:2];
            memBe_d    = byteEnables(bus.acc_mode, bus.addr[1:0]);
            memWdata_d = storeLanes(bus.acc_mode, bus.wdata);
            accMode_d  = bus.acc_mode;
            offset_d   = bus.addr[1:0];
            state_d    = REQ;
`ifdef DMEM_TIMEOUT_EN
            waitCnt_d  = 32'd0;
`endif
          end else begin
            misalign_d = 1'b1;
          end
        end
      end

      REQ: begin
        stall = 1'b1;
        if (bus.mem_ack) begin
          memReq_d = 1'b0;
          state_d  = DONE;
          if (!memWe_q) begin
            rdata_d = formatLoad(accMode_q, offset_q, bus.mem_rdata);
          end
`ifdef DMEM_TIMEOUT_EN
        end else if (waitCnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          memReq_d = 1'b0;
          busErr_d = 1'b1;
          state_d  = DONE;
        end else begin
          waitCnt_d = waitCnt_q + 32'd1;
`endif
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d  = IDLE;
        memReq_d = 1'b0;
      end
    endcase

    if (reset) begin
      stall = 1'b0;
    end
  end

  // State and output registers; reset clears everything, which also drops
  // an in-flight mem_req and discards any ack that arrives afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= 30'd0;
      memBe_q    <= 4'd0;
      memWdata_q <= 32'd0;
      accMode_q  <= 3'd0;
      offset_q   <= 2'd0;
      rdata_q    <= 32'd0;
      misalign_q <= 1'b0;
      busErr_q   <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      waitCnt_q  <= 32'd0;
`endif
    end else begin
      state_q    <= state_d;
      memReq_q   <= memReq_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memBe_q    <= memBe_d;
      memWdata_q <= memWdata_d;
      accMode_q  <= accMode_d;
      offset_q   <= offset_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
      busErr_q   <= busErr_d;
`ifdef DMEM_TIMEOUT_EN
      waitCnt_q  <= waitCnt_d;
`endif
    end
  end

`ifdef DMEM_TIMEOUT_EN
  assign bus.bus_err = busErr_q;
`else
  // The timeout parameter and the error register only matter when the
  // timeout is built in; keep them referenced so the default build is clean.
  logic unusedTimeout;
  assign unusedTimeout = (|TIMEOUT_CYCLES) ^ busErr_q;
  assign bus.bus_err   = 1'b0;
`endif

  assign bus.rdata     = rdata_q;
  assign bus.stall     = stall;
  assign bus.misalign  = misalign_q;
  assign bus.mem_req   = memReq_q;
  assign bus.mem_we    = memWe_q;
  assign bus.mem_addr  = memAddr_q;
  assign bus.mem_be    = memBe_q;
  assign bus.mem_wdata = memWdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_dmem_access_unit
//   Directed self-checking bench for dmem_access_unit. Each scenario task
//   drives the pipeline request and plays the memory (ack/rdata), comparing
//   DUT outputs against hand-computed values. Inputs change 1ns after the
//   rising edge; outputs are sampled 1-2ns after the edge.
//   With DMEM_TIMEOUT_EN defined the DUT uses TIMEOUT_CYCLES = 4.
// ---------------------------------------------------------------------------
module tb_dmem_access_unit;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  logic [31:0] expRdata;

  dmem_access_unit_if bus ();

  dmem_access_unit #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 10ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a scenario never returns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exceeded, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] mode,
                               input logic [31:0] a, input logic [31:0] wd);
    bus.req_read  = rd;
    bus.req_write = wr;
    bus.acc_mode  = mode;
    bus.addr      = a;
    bus.wdata     = wd;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 3'd0, 32'h0, 32'h0);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    tick;
    tick;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("[TB] FAIL rst_stall: got %b want 0", bus.stall); end
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_rdata: got %h want 0", bus.rdata); end
    checks++; if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL rst_req_we: got %b%b want 00", bus.mem_req, bus.mem_we); end
    checks++; if (bus.mem_addr !== 30'h0 || bus.mem_be !== 4'h0 || bus.mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_bus: got %h %h %h want 0 0 0", bus.mem_addr, bus.mem_be, bus.mem_wdata); end
    checks++; if (bus.misalign !== 1'b0 || bus.bus_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_flags: got %b%b want 00", bus.misalign, bus.bus_err); end
    applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    reset = 1'b0;
    tick;
    expRdata = 32'h0;
  endtask

  task automatic test_word_store;
    int stallCycles;
    stallCycles = 0;
    applyStimulus(1'b0, 1'b1, 3'd0, 32'h100, 32'hDEADBEEF);
    #1;
    if (bus.stall === 1'b1) stallCycles++;
    tick;
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin errors++; $display("[TB] FAIL ws_req_we: got %b%b want 11", bus.mem_req, bus.mem_we); end
    checks++; if (bus.mem_addr !== 30'h40) begin errors++; $display("[TB] FAIL ws_addr: got %h want 40", bus.mem_addr); end
    checks++; if (bus.mem_be !== 4'b1111) begin errors++; $display("[TB] FAIL ws_be: got %b want 1111", bus.mem_be); end
    checks++; if (bus.mem_wdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL ws_wdata: got %h want deadbeef", bus.mem_wdata); end
    if (bus.stall === 1'b1) stallCycles++;
    tick;
    bus.mem_ack = 1'b1;
    #1;
    if (bus.stall === 1'b1) stallCycles++;
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("[TB] FAIL ws_req_held: got %b want 1", bus.mem_req); end
    tick;
    bus.mem_ack = 1'b0;
    #1;
    checks++; if (stallCycles !== 3) begin errors++; $display("[TB] FAIL ws_stall_cycles: got %0d want 3", stallCycles); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("[TB] FAIL ws_done_stall: got %b want 0", bus.stall); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL ws_req_drop: got %b want 0", bus.mem_req); end
    tick;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL ws_no_reaccept: got %b want 0", bus.mem_req); end
    applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    tick;
  endtask

  task automatic test_loads;
    logic [2:0]  modes [6] = '{3'd3, 3'd4, 3'd2, 3'd1, 3'd0, 3'd3};
    logic [31:0] addrs [6] = '{32'h203, 32'h203, 32'h202, 32'h200, 32'h204, 32'h201};
    logic [31:0] raws  [6] = '{32'h80123456, 32'h80123456, 32'hBEEF1234, 32'h12348765, 32'hCAFEF00D, 32'h00007F00};
    logic [3:0]  bes   [6] = '{4'b1000, 4'b1000, 4'b1100, 4'b0011, 4'b1111, 4'b0010};
    logic [31:0] exps  [6] = '{32'hFFFFFF80, 32'h00000080, 32'h0000BEEF, 32'hFFFF8765, 32'hCAFEF00D, 32'h0000007F};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, modes[i], addrs[i], 32'h0);
      #1;
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("[TB] FAIL ld%0d_accept_stall: got %b want 1", i, bus.stall); end
      tick;
      checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_be !== bes[i]) begin errors++; $display("[TB] FAIL ld%0d_bus: got req=%b we=%b be=%b want req=1 we=0 be=%b", i, bus.mem_req, bus.mem_we, bus.mem_be, bes[i]); end
      checks++; if (bus.mem_addr !== addrs[i][31:2]) begin errors++; $display("[TB] FAIL ld%0d_addr: got %h want %h", i, bus.mem_addr, addrs[i][31:2]); end
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = raws[i];
      tick;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'h0;
      #1;
      checks++; if (bus.rdata !== exps[i]) begin errors++; $display("[TB] FAIL ld%0d_rdata: got %h want %h", i, bus.rdata, exps[i]); end
      checks++; if (bus.stall !== 1'b0 || bus.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL ld%0d_done: got stall=%b req=%b want 0 0", i, bus.stall, bus.mem_req); end
      expRdata = exps[i];
      applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      tick;
    end
  endtask

  task automatic test_stores;
    logic [2:0]  modes [3] = '{3'd2, 3'd4, 3'd1};
    logic [31:0] addrs [3] = '{32'h202, 32'h201, 32'h200};
    logic [31:0] wds   [3] = '{32'h0000CAFE, 32'h123456A5, 32'hFFFF1357};
    logic [3:0]  bes   [3] = '{4'b1100, 4'b0010, 4'b0011};
    logic [31:0] lanes [3] = '{32'hCAFECAFE, 32'hA5A5A5A5, 32'h13571357};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, modes[i], addrs[i], wds[i]);
      tick;
      checks++; if (bus.mem_we !== 1'b1 || bus.mem_be !== bes[i]) begin errors++; $display("[TB] FAIL st%0d_be: got we=%b be=%b want we=1 be=%b", i, bus.mem_we, bus.mem_be, bes[i]); end
      checks++; if (bus.mem_wdata !== lanes[i]) begin errors++; $display("[TB] FAIL st%0d_wdata: got %h want %h", i, bus.mem_wdata, lanes[i]); end
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h99999999;
      tick;
      bus.mem_ack   = 1'b0;
      checks++; if (bus.rdata !== expRdata) begin errors++; $display("[TB] FAIL st%0d_rdata_kept: got %h want %h", i, bus.rdata, expRdata); end
      applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      tick;
    end
  endtask

  task automatic test_write_priority;
    applyStimulus(1'b1, 1'b1, 3'd0, 32'h300, 32'h11223344);
    tick;
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 30'hC0 || bus.mem_wdata !== 32'h11223344) begin errors++; $display("[TB] FAIL wp_bus: got we=%b addr=%h wd=%h want 1 c0 11223344", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h77777777;
    tick;
    bus.mem_ack   = 1'b0;
    checks++; if (bus.rdata !== expRdata) begin errors++; $display("[TB] FAIL wp_rdata_kept: got %h want %h", bus.rdata, expRdata); end
    applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    tick;
  endtask

  task automatic test_illegal;
    logic [2:0]  modes [3] = '{3'd0, 3'd6, 3'd1};
    logic [31:0] addrs [3] = '{32'h101, 32'h100, 32'h203};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, modes[i], addrs[i], 32'h0);
      #1;
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("[TB] FAIL il%0d_stall: got %b want 0", i, bus.stall); end
      tick;
      applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      checks++; if (bus.misalign !== 1'b1 || bus.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL il%0d_pulse: got misalign=%b req=%b want 1 0", i, bus.misalign, bus.mem_req); end
      checks++; if (bus.rdata !== expRdata) begin errors++; $display("[TB] FAIL il%0d_rdata: got %h want %h", i, bus.rdata, expRdata); end
      tick;
      checks++; if (bus.misalign !== 1'b0 || bus.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL il%0d_after: got misalign=%b req=%b want 0 0", i, bus.misalign, bus.mem_req); end
    end
  endtask

  task automatic test_stray_ack;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFFFFFF;
    tick;
    bus.mem_ack   = 1'b0;
    tick;
    checks++; if (bus.rdata !== expRdata || bus.mem_req !== 1'b0 || bus.stall !== 1'b0) begin errors++; $display("[TB] FAIL stray_ack: got rdata=%h req=%b stall=%b want %h 0 0", bus.rdata, bus.mem_req, bus.stall, expRdata); end
  endtask

  task automatic test_reset_mid_op;
    applyStimulus(1'b1, 1'b0, 3'd0, 32'h400, 32'h0);
    tick;
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("[TB] FAIL rm_req: got %b want 1", bus.mem_req); end
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("[TB] FAIL rm_stall_in_reset: got %b want 0", bus.stall); end
    tick;
    reset = 1'b0;
    expRdata = 32'h0;
    checks++; if (bus.mem_req !== 1'b0 || bus.rdata !== 32'h0) begin errors++; $display("[TB] FAIL rm_cleared: got req=%b rdata=%h want 0 0", bus.mem_req, bus.rdata); end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h00000055;
    tick;
    bus.mem_ack   = 1'b0;
    checks++; if (bus.mem_req !== 1'b0 || bus.stall !== 1'b0 || bus.rdata !== 32'h0) begin errors++; $display("[TB] FAIL rm_late_ack: got req=%b stall=%b rdata=%h want 0 0 0", bus.mem_req, bus.stall, bus.rdata); end
    tick;
  endtask

`ifdef DMEM_TIMEOUT_EN
  task automatic test_timeout;
    int reqCycles;
    reqCycles = 0;
    applyStimulus(1'b1, 1'b0, 3'd0, 32'h500, 32'h0);
    tick;
    while (bus.mem_req === 1'b1 && reqCycles < 20) begin
      reqCycles++;
      checks++; if (bus.bus_err !== 1'b0) begin errors++; $display("[TB] FAIL to_early_err: got %b want 0", bus.bus_err); end
      tick;
    end
    checks++; if (reqCycles !== 4) begin errors++; $display("[TB] FAIL to_req_cycles: got %0d want 4", reqCycles); end
    checks++; if (bus.bus_err !== 1'b1 || bus.stall !== 1'b0) begin errors++; $display("[TB] FAIL to_abort: got err=%b stall=%b want 1 0", bus.bus_err, bus.stall); end
    checks++; if (bus.rdata !== expRdata) begin errors++; $display("[TB] FAIL to_rdata: got %h want %h", bus.rdata, expRdata); end
    applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    tick;
    checks++; if (bus.bus_err !== 1'b0) begin errors++; $display("[TB] FAIL to_pulse_width: got %b want 0", bus.bus_err); end

    applyStimulus(1'b1, 1'b0, 3'd0, 32'h504, 32'h0);
    tick;
    applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    tick;
    tick;
    tick;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hA5A5A5A5;
    tick;
    bus.mem_ack   = 1'b0;
    expRdata = 32'hA5A5A5A5;
    checks++; if (bus.bus_err !== 1'b0 || bus.rdata !== 32'hA5A5A5A5 || bus.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL to_ack_at_limit: got err=%b rdata=%h req=%b want 0 a5a5a5a5 0", bus.bus_err, bus.rdata, bus.mem_req); end
    tick;
  endtask
`else
  task automatic test_timeout;
    int badCycles;
    badCycles = 0;
    applyStimulus(1'b1, 1'b0, 3'd0, 32'h500, 32'h0);
    tick;
    for (int i = 0; i < 20; i++) begin
      if (bus.mem_req !== 1'b1 || bus.bus_err !== 1'b0 || bus.stall !== 1'b1) badCycles++;
      tick;
    end
    checks++; if (badCycles !== 0) begin errors++; $display("[TB] FAIL nto_wait: got %0d bad cycles want 0", badCycles); end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0BADF00D;
    tick;
    bus.mem_ack   = 1'b0;
    expRdata = 32'h0BADF00D;
    checks++; if (bus.rdata !== 32'h0BADF00D || bus.bus_err !== 1'b0 || bus.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL nto_late_ack: got rdata=%h err=%b req=%b want 0badf00d 0 0", bus.rdata, bus.bus_err, bus.mem_req); end
    applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    tick;
  endtask
`endif

  initial begin
    errors   = 0;
    checks   = 0;
    expRdata = 32'h0;
    test_reset;
    test_word_store;
    test_loads;
    test_stores;
    test_write_priority;
    test_illegal;
    test_stray_ack;
    test_reset_mid_op;
    test_timeout;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
